shift_pipe: RTL and testbench

- Parametrised, pipelined barrel shifter. Successor to the 32-bit combinational SHIFT32 family.
- Supports logical left, logical right, arithmetic right and rotate right.
- Has a valid/ready handshake on input and output, with full backpressure.
- Sits between the ALU operand muxes and the result writeback path, so long shift chains can be retimed without touching the ALU.

---
 rtl/shift_pipe.sv | 148 ++++++++++++++
 tb/tb_shift_pipe.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SLL, SRL, SRA, ROR) with valid/ready
// handshake on both sides and a global stall. One mux level per shift-amount
// bit; a register closes every REG_EVERY levels and always the last level.
module shift_pipe #(
    parameter int WIDTH     = 32,
    parameter int SHW       = $clog2(WIDTH),
    parameter int REG_EVERY = 1,
    parameter int TAGW      = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_valid,
    output logic             i_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_amt,
    input  logic [1:0]       i_mode,
    input  logic [TAGW-1:0]  i_tag,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [TAGW-1:0]  o_tag,
    output logic             o_zero
);

    typedef enum logic [1:0] {
        MODE_SLL = 2'b00,
        MODE_SRL = 2'b01,
        MODE_SRA = 2'b10,
        MODE_ROR = 2'b11
    } shiftMode_e;

    // Index k is the input of mux level k; index k+1 is its (possibly registered) output.
    logic [WIDTH-1:0] lvlData  [0:SHW];
    logic             lvlValid [0:SHW];
    logic [TAGW-1:0]  lvlTag   [0:SHW];
    logic [SHW-1:0]   lvlAmt   [0:SHW-1];
    shiftMode_e       lvlMode  [0:SHW-1];
    logic             lvlSign  [0:SHW-1];
    logic [WIDTH-1:0] lvlMux   [0:SHW-1];

    logic adv;
    logic zeroQ;

    // Global stall: everything holds while the output is presented but not taken.
    assign adv     = ~(lvlValid[SHW] & ~o_ready);
    assign i_ready = adv;

    assign lvlData[0]  = i_data;
    assign lvlValid[0] = i_valid;
    assign lvlTag[0]   = i_tag;
    assign lvlAmt[0]   = i_amt;
    assign lvlMode[0]  = shiftMode_e'(i_mode);
    // Sign is captured once at the input so SRA fill never depends on intermediate data.
    assign lvlSign[0]  = i_data[WIDTH-1];

    for (genvar k = 0; k < SHW; k++) begin : gLevel
        localparam int SH = 1 << k;
        localparam bit IS_LAST = (k == SHW - 1);
        localparam bit HAS_REG = IS_LAST || (((k + 1) % REG_EVERY) == 0);
        localparam logic [WIDTH-1:0] SIGN_FILL = ~({WIDTH{1'b1}} >> SH);

        logic [WIDTH-1:0] muxOut;

        // Mux level k: shift by 2^k when amount bit k is set
        always_comb begin
            muxOut = lvlData[k];
            if (lvlAmt[k][k]) begin
                case (lvlMode[k])
                    MODE_SLL: muxOut = lvlData[k] << SH;
                    MODE_SRL: muxOut = lvlData[k] >> SH;
                    MODE_SRA: muxOut = (lvlData[k] >> SH) | (lvlSign[k] ? SIGN_FILL : '0);
                    MODE_ROR: muxOut = (lvlData[k] >> SH) | (lvlData[k] << (WIDTH - SH));
                    default:  muxOut = lvlData[k];
                endcase
            end
        end

        assign lvlMux[k] = muxOut;

        if (HAS_REG) begin : gReg
            logic [WIDTH-1:0] dataQ;
            logic             validQ;
            logic [TAGW-1:0]  tagQ;

            // Stage register for data, valid and tag; advances with all other stages
            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    dataQ  <= '0;
                    validQ <= 1'b0;
                    tagQ   <= '0;
                end else if (adv) begin
                    dataQ  <= muxOut;
                    validQ <= lvlValid[k];
                    tagQ   <= lvlTag[k];
                end
            end

            assign lvlData[k+1]  = dataQ;
            assign lvlValid[k+1] = validQ;
            assign lvlTag[k+1]   = tagQ;

            if (!IS_LAST) begin : gSide
                logic [SHW-1:0] amtQ;
                shiftMode_e     modeQ;
                logic           signQ;

                // Control sideband travelling with the data to later mux levels
                always_ff @(posedge CLK or negedge RST) begin
                    if (!RST) begin
                        amtQ  <= '0;
                        modeQ <= MODE_SLL;
                        signQ <= 1'b0;
                    end else if (adv) begin
                        amtQ  <= lvlAmt[k];
                        modeQ <= lvlMode[k];
                        signQ <= lvlSign[k];
                    end
                end

                assign lvlAmt[k+1]  = amtQ;
                assign lvlMode[k+1] = modeQ;
                assign lvlSign[k+1] = signQ;
            end
        end else begin : gPass
            assign lvlData[k+1]  = muxOut;
            assign lvlValid[k+1] = lvlValid[k];
            assign lvlTag[k+1]   = lvlTag[k];
            assign lvlAmt[k+1]   = lvlAmt[k];
            assign lvlMode[k+1]  = lvlMode[k];
            assign lvlSign[k+1]  = lvlSign[k];
        end
    end

    // Zero flag registered alongside the final data stage
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            zeroQ <= 1'b1;
        end else if (adv) begin
            zeroQ <= (lvlMux[SHW-1] == '0);
        end
    end

    assign o_valid = lvlValid[SHW];
    assign o_data  = lvlData[SHW];
    assign o_tag   = lvlTag[SHW];
    assign o_zero  = zeroQ;

endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: four shift_pipe instances (W32/R1, W32/R2, W32/R5, W8/R1) fed
// the same operations; a bit-level reference model fills per-instance queues
// on acceptance and an independent monitor pops and compares on handshake.
module tb_shift_pipe;

    localparam int N = 4;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        zero;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [N-1:0]    iValid;
    logic [N-1:0]    iReady;
    logic [31:0]     iData;
    logic [4:0]      iAmt;
    logic [1:0]      iMode;
    logic [3:0]      iTag;
    logic [N-1:0]    oValid;
    logic [N-1:0]    oReady;
    logic [31:0]     oData [N];
    logic [3:0]      oTag  [N];
    logic [N-1:0]    oZero;

    exp_t            q [N][$];
    int              checks = 0;
    int              errors = 0;
    int              cyc = 0;
    int              readyMode = 0;   // 0: always ready, 1: random 50%
    int              stallLo = -1;
    int              stallHi = -2;
    logic [N-1:0]    pending;
    logic [31:0]     stData;
    logic [4:0]      stAmt;
    logic [1:0]      stMode;
    logic [3:0]      stTag;

    for (genvar g = 0; g < N; g++) begin : gDut
        localparam int W = (g == 3) ? 8 : 32;
        localparam int R = (g == 1) ? 2 : ((g == 2) ? 5 : 1);
        localparam int S = $clog2(W);
        logic [W-1:0] od;

        shift_pipe #(.WIDTH(W), .REG_EVERY(R), .TAGW(4)) dut (
            .CLK    (clk),
            .RST    (rst),
            .i_valid(iValid[g]),
            .i_ready(iReady[g]),
            .i_data (iData[W-1:0]),
            .i_amt  (iAmt[S-1:0]),
            .i_mode (iMode),
            .i_tag  (iTag),
            .o_valid(oValid[g]),
            .o_ready(oReady[g]),
            .o_data (od),
            .o_tag  (oTag[g]),
            .o_zero (oZero[g])
        );

        assign oData[g] = 32'(od);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int widthOf(int g);
        return (g == 3) ? 8 : 32;
    endfunction

    function automatic int latOf(int g);
        case (g)
            0: return 5;
            1: return 3;
            2: return 1;
            default: return 3;
        endcase
    endfunction

    // Reference: each result bit defined directly by where it comes from.
    function automatic logic [31:0] model(int w, logic [31:0] d, int s, logic [1:0] m);
        logic [31:0] r;
        r = '0;
        for (int j = 0; j < w; j++) begin
            case (m)
                2'b00:   r[j] = (j >= s) ? d[j-s] : 1'b0;
                2'b01:   r[j] = (j + s < w) ? d[j+s] : 1'b0;
                2'b10:   r[j] = (j + s < w) ? d[j+s] : d[w-1];
                default: r[j] = d[(j + s) % w];
            endcase
        end
        return r;
    endfunction

    task automatic chk(string name, int g, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got %h expected %h", name, g, got, exp);
        end
    endtask

    task automatic failNow(string name);
        checks++;
        errors++;
        $display("FAIL %s bound expired at cycle %0d", name, cyc);
    endtask

    function automatic bit busy();
        for (int g = 0; g < N; g++) if (q[g].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive at the falling edge, record acceptances just after.
    task automatic cycle();
        @(negedge clk);
        cyc++;
        iData = stData;
        iAmt  = stAmt;
        iMode = stMode;
        iTag  = stTag;
        for (int g = 0; g < N; g++)
            oReady[g] = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (cyc >= stallLo && cyc <= stallHi) oReady = '0;
        iValid = pending;
        #1;
        for (int g = 0; g < N; g++) begin
            if (pending[g] && iReady[g]) begin
                exp_t e;
                int w;
                logic [31:0] mask;
                w = widthOf(g);
                mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
                e.data = model(w, stData & mask, int'(stAmt) % w, stMode);
                e.tag  = stTag;
                e.zero = (e.data == 32'd0);
                q[g].push_back(e);
                pending[g] = 1'b0;
            end
        end
    endtask

    task automatic issue(logic [31:0] d, logic [4:0] a, logic [1:0] m, logic [3:0] t);
        int n;
        stData  = d;
        stAmt   = a;
        stMode  = m;
        stTag   = t;
        pending = '1;
        n = 0;
        while (pending != '0 && n < 200) begin
            cycle();
            n++;
        end
        if (pending != '0) begin
            failNow("accept_timeout");
            pending = '0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy() && n < 400) begin
            cycle();
            n++;
        end
        if (busy()) failNow("drain_timeout");
    endtask

    // Monitor: compares on every handshake, and checks held outputs during stalls.
    initial begin
        logic [N-1:0] stalled;
        stalled = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                stalled = '0;
                continue;
            end
            for (int g = 0; g < N; g++) begin
                chk("i_ready", g, 32'(iReady[g]), 32'(!(oValid[g] && !oReady[g])));
                if (stalled[g]) chk("valid_held", g, 32'(oValid[g]), 32'd1);
                if (oValid[g]) begin
                    if (q[g].size() == 0) begin
                        failNow($sformatf("extra_result dut%0d", g));
                        stalled[g] = 1'b0;
                    end else begin
                        exp_t e;
                        e = oReady[g] ? q[g].pop_front() : q[g][0];
                        chk(oReady[g] ? "data" : "stall_data", g, oData[g], e.data);
                        chk(oReady[g] ? "tag" : "stall_tag", g, 32'(oTag[g]), 32'(e.tag));
                        chk(oReady[g] ? "zero" : "stall_zero", g, 32'(oZero[g]), 32'(e.zero));
                        stalled[g] = !oReady[g];
                    end
                end else begin
                    stalled[g] = 1'b0;
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog simulation time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int latSeen [N];
        rst     = 1'b1;
        iValid  = '0;
        oReady  = '1;
        pending = '0;
        stData  = '0;
        stAmt   = '0;
        stMode  = '0;
        stTag   = '0;
        iData   = '0;
        iAmt    = '0;
        iMode   = '0;
        iTag    = '0;
        #1 rst = 1'b0;
        #1;
        for (int g = 0; g < N; g++) begin
            chk("reset_valid", g, 32'(oValid[g]), 32'd0);
            chk("reset_zero", g, 32'(oZero[g]), 32'd1);
            chk("reset_data", g, oData[g], 32'd0);
            chk("reset_tag", g, 32'(oTag[g]), 32'd0);
        end
        @(posedge clk);
        #2 rst = 1'b1;

        // Latency from an empty pipe: SLL 1 by max amount
        issue(32'h0000_0001, 5'd31, 2'b00, 4'h1);
        for (int g = 0; g < N; g++) latSeen[g] = -1;
        for (int n = 1; n <= 12; n++) begin
            cycle();
            for (int g = 0; g < N; g++)
                if (latSeen[g] < 0 && oValid[g]) latSeen[g] = n;
        end
        for (int g = 0; g < N; g++) chk("latency", g, 32'(latSeen[g]), 32'(latOf(g)));
        drain();

        // Directed operations, including amount 0 and the narrow-width vectors
        issue(32'h8000_0000, 5'd4, 2'b10, 4'h2);
        issue(32'h0000_00F1, 5'd4, 2'b11, 4'h3);
        issue(32'hFFFF_FFFF, 5'd0, 2'b01, 4'h4);
        issue(32'h0000_0008, 5'd4, 2'b01, 4'h5);
        issue(32'h0000_0090, 5'd7, 2'b10, 4'h6);
        issue(32'h0000_0081, 5'd1, 2'b11, 4'h7);
        issue(32'hDEAD_BEEF, 5'd0, 2'b00, 4'h8);
        issue(32'h8765_4321, 5'd31, 2'b10, 4'h9);
        drain();

        // Burst of eight with a four-cycle output stall in the middle
        stallLo = cyc + 6;
        stallHi = cyc + 9;
        for (int t = 0; t < 8; t++)
            issue($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 4'(t));
        drain();
        stallLo = -1;
        stallHi = -2;

        // Random operations against random backpressure and input bubbles
        readyMode = 1;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 7) == 0) cycle();
            issue($urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
                  4'($urandom_range(0, 15)));
        end
        drain();

        // Asynchronous reset with operations in flight
        readyMode = 0;
        issue(32'h0000_0011, 5'd2, 2'b00, 4'hA);
        issue(32'h0000_0022, 5'd3, 2'b01, 4'hB);
        issue(32'h0000_0033, 5'd1, 2'b11, 4'hC);
        @(posedge clk);
        #2;
        rst    = 1'b0;
        iValid = '0;
        #1;
        for (int g = 0; g < N; g++) begin
            chk("async_reset_valid", g, 32'(oValid[g]), 32'd0);
            chk("async_reset_zero", g, 32'(oZero[g]), 32'd1);
            q[g].delete();
        end
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        issue(32'h0000_0001, 5'd1, 2'b00, 4'hD);
        drain();
        for (int n = 0; n < 8; n++) cycle();

        for (int g = 0; g < N; g++) chk("queue_empty", g, 32'(q[g].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
